pattern_drawer: RTL

Parametrised successor to the fixed border/split drawer. It takes the raster position and display-enable from the vga sync generator and produces registered RGB from a frame-latched pattern mode. Modes are border+split, colour bars, checkerboard, bouncing box and gradient. Sync signals are delayed so they stay aligned with the 1-cycle colour pipeline. It sits between the vga sync generator and the DAC/pad outputs.

---
 rtl/vga_pkg.sv | 20 ++
 rtl/bounce_axis.sv | 52 +++++
 rtl/pattern_drawer.sv | 162 ++++++++++++++++
 3 files changed

// File: rtl/vga_pkg.sv
// Shared constants for the pattern drawer: mode encodings, bounce directions
// and the colour-bar table.
package vga_pkg;

    localparam logic [2:0] MODE_BORDER = 3'd0;
    localparam logic [2:0] MODE_BARS   = 3'd1;
    localparam logic [2:0] MODE_CHECK  = 3'd2;
    localparam logic [2:0] MODE_BOX    = 3'd3;
    localparam logic [2:0] MODE_GRAD   = 3'd4;

    localparam logic DIR_INC = 1'b0;
    localparam logic DIR_DEC = 1'b1;

    // {R,G,B} masks, index 0 = white ... index 7 = black
    localparam logic [7:0][2:0] BAR_RGB = {
        3'b000, 3'b001, 3'b100, 3'b101,
        3'b010, 3'b011, 3'b110, 3'b111
    };

endpackage

// File: rtl/bounce_axis.sv
// One axis of the bouncing box: moves by STEP per tick, clamping and
// reversing at 0 and LIMIT.
module bounce_axis
    import vga_pkg::*;
#(
    parameter int unsigned W     = 10,
    parameter int unsigned LIMIT = 608,
    parameter int unsigned STEP  = 2
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         tick,
    output logic [W-1:0] pos,
    output logic         dir
);

    localparam logic [W:0] LIMIT_EXT = (W+1)'(LIMIT);
    localparam logic [W:0] STEP_EXT  = (W+1)'(STEP);

    logic [W:0] pos_ext;
    logic [W:0] pos_up;
    logic [W:0] pos_dn;

    // one extra bit keeps the overshoot test free of wrap-around
    assign pos_ext = {1'b0, pos};
    assign pos_up  = pos_ext + STEP_EXT;
    assign pos_dn  = pos_ext - STEP_EXT;

    always_ff @(posedge clk) begin
        if (reset) begin
            pos <= '0;
            dir <= DIR_INC;
        end else if (tick) begin
            if (dir == DIR_INC) begin
                if (pos_up > LIMIT_EXT) begin
                    pos <= W'(LIMIT);
                    dir <= DIR_DEC;
                end else begin
                    pos <= pos_up[W-1:0];
                end
            end else begin
                if (pos_ext < STEP_EXT) begin
                    pos <= '0;
                    dir <= DIR_INC;
                end else begin
                    pos <= pos_dn[W-1:0];
                end
            end
        end
    end

endmodule

// File: rtl/pattern_drawer.sv
// Test-pattern generator between the VGA sync generator and the DAC pads;
// one registered colour stage with syncs delayed to match.
module pattern_drawer
    import vga_pkg::*;
#(
    parameter int unsigned CW         = 10,
    parameter int unsigned COLOR_W    = 8,
    parameter int unsigned MIN_X      = 64,
    parameter int unsigned MIN_Y      = 16,
    parameter int unsigned H_ACT      = 640,
    parameter int unsigned V_ACT      = 480,
    parameter int unsigned CHECK_LOG2 = 5,
    parameter int unsigned BOX_SIZE   = 32,
    parameter int unsigned BOX_STEP   = 2
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [CW-1:0]      CounterX,
    input  logic [CW-1:0]      CounterY,
    input  logic               inDisplayArea,
    input  logic               h_sync_in,
    input  logic               v_sync_in,
    input  logic [2:0]         mode_sel,
    output logic [COLOR_W-1:0] vga_R,
    output logic [COLOR_W-1:0] vga_G,
    output logic [COLOR_W-1:0] vga_B,
    output logic               vga_h_sync,
    output logic               vga_v_sync,
    output logic               frame_start,
    output logic [2:0]         mode_active
);

    localparam logic [CW:0]      X_BEG   = (CW+1)'(MIN_X);
    localparam logic [CW:0]      X_END   = (CW+1)'(MIN_X + H_ACT);
    localparam logic [CW:0]      Y_BEG   = (CW+1)'(MIN_Y);
    localparam logic [CW:0]      Y_END   = (CW+1)'(MIN_Y + V_ACT);
    localparam logic [CW-1:0]    XR_LAST = CW'(H_ACT - 1);
    localparam logic [CW-1:0]    YR_LAST = CW'(V_ACT - 1);
    localparam logic [CW-1:0]    X_HALF  = CW'(H_ACT / 2);
    localparam logic [CW-1:0]    BAR_W   = CW'(H_ACT / 8);
    localparam logic [CW:0]      BOX_EXT = (CW+1)'(BOX_SIZE);
    localparam logic [COLOR_W-1:0] FULL  = {COLOR_W{1'b1}};

    logic               ftick;
    logic [CW-1:0]      xr;
    logic [CW-1:0]      yr;
    logic [CW:0]        xr_ext;
    logic [CW:0]        yr_ext;
    logic               act;
    logic               edge_px;
    logic               in_box;
    logic [CW-1:0]      bar_q;
    logic [2:0]         bar_idx;
    logic [2:0]         bar_mask;
    logic [CW-1:0]      box_x;
    logic [CW-1:0]      box_y;
    logic               dir_x;
    logic               dir_y;
    logic [1:0]         box_dir_unused;
    logic [COLOR_W-1:0] r_nxt;
    logic [COLOR_W-1:0] g_nxt;
    logic [COLOR_W-1:0] b_nxt;

    assign ftick = (CounterX == '0) && (CounterY == '0) && !reset;

    bounce_axis #(.W(CW), .LIMIT(H_ACT - BOX_SIZE), .STEP(BOX_STEP)) u_box_x (
        .clk   (clk),
        .reset (reset),
        .tick  (ftick),
        .pos   (box_x),
        .dir   (dir_x)
    );

    bounce_axis #(.W(CW), .LIMIT(V_ACT - BOX_SIZE), .STEP(BOX_STEP)) u_box_y (
        .clk   (clk),
        .reset (reset),
        .tick  (ftick),
        .pos   (box_y),
        .dir   (dir_y)
    );

    assign box_dir_unused = {dir_x, dir_y};

    // Raster decode shared by every mode
    assign xr      = CounterX - CW'(MIN_X);
    assign yr      = CounterY - CW'(MIN_Y);
    assign xr_ext  = {1'b0, xr};
    assign yr_ext  = {1'b0, yr};
    assign act     = inDisplayArea
                  && ({1'b0, CounterX} >= X_BEG) && ({1'b0, CounterX} < X_END)
                  && ({1'b0, CounterY} >= Y_BEG) && ({1'b0, CounterY} < Y_END);
    assign edge_px = (xr == '0) || (xr == XR_LAST) || (yr == '0) || (yr == YR_LAST);
    assign in_box  = (xr_ext >= {1'b0, box_x}) && (xr_ext < {1'b0, box_x} + BOX_EXT)
                  && (yr_ext >= {1'b0, box_y}) && (yr_ext < {1'b0, box_y} + BOX_EXT);
    assign bar_q    = xr / BAR_W;
    assign bar_idx  = (bar_q > CW'(7)) ? 3'd7 : bar_q[2:0];
    assign bar_mask = BAR_RGB[bar_idx];

    always_comb begin
        r_nxt = '0;
        g_nxt = '0;
        b_nxt = '0;
        if (act) begin
            case (mode_active)
                MODE_BORDER: begin
                    if (edge_px) begin
                        r_nxt = FULL;
                        g_nxt = FULL;
                    end
                    if (xr >= X_HALF) b_nxt = FULL;
                end
                MODE_BARS: begin
                    r_nxt = {COLOR_W{bar_mask[2]}};
                    g_nxt = {COLOR_W{bar_mask[1]}};
                    b_nxt = {COLOR_W{bar_mask[0]}};
                end
                MODE_CHECK: begin
                    if (xr[CHECK_LOG2] ^ yr[CHECK_LOG2]) begin
                        r_nxt = FULL;
                        g_nxt = FULL;
                        b_nxt = FULL;
                    end
                end
                MODE_BOX: begin
                    if (in_box) r_nxt = FULL;
                    if (edge_px) begin
                        r_nxt = FULL;
                        g_nxt = FULL;
                        b_nxt = FULL;
                    end
                end
                MODE_GRAD: begin
                    r_nxt = xr[COLOR_W-1:0];
                    g_nxt = yr[COLOR_W-1:0];
                end
                default: ;
            endcase
        end
    end

    // Output stage; mode is only switched at the frame tick
    always_ff @(posedge clk) begin
        if (reset) begin
            vga_R       <= '0;
            vga_G       <= '0;
            vga_B       <= '0;
            vga_h_sync  <= 1'b1;
            vga_v_sync  <= 1'b1;
            frame_start <= 1'b0;
            mode_active <= MODE_BORDER;
        end else begin
            vga_R       <= r_nxt;
            vga_G       <= g_nxt;
            vga_B       <= b_nxt;
            vga_h_sync  <= h_sync_in;
            vga_v_sync  <= v_sync_in;
            frame_start <= ftick;
            if (ftick) mode_active <= mode_sel;
        end
    end

endmodule
